weight_bias_read_scheduler: RTL
===============================

// Module: weight_bias_read_scheduler
// PURPOSE
//  Owns the shared weight/bias SRAM read port between layer1 and layer2 engines.
//  Grants exclusive ownership via req/release handshake and round-robin on contention.
//  Drives weight_sel/bias_sel of the weight/bias read mux.
//  Tags returning read data with the issuing layer so each engine gets its own valid strobe.
// PARAMETERS
//  READ_LATENCY  1    cycles from read signal (mux output) to SRAM data; 1..4
//  MAX_HOLD      256  max cycles one owner may hold the grant (used only with SCHED_TIMEOUT_EN)
// PORTS
//  clk                    in   1   clock, rising edge
//  rst                    in   1   async reset, active-high
//  layer1_req             in   1   layer1 requests ownership, level
//  layer2_req             in   1   layer2 requests ownership, level
//  layer1_release         in   1   layer1 gives up ownership, 1-cycle pulse
//  layer2_release         in   1   layer2 gives up ownership, 1-cycle pulse
//  read_weight_signal_data in  1   muxed weight read strobe (from the read mux)
//  read_bias_signal_data  in   1   muxed bias read strobe (from the read mux)
//  weight_sel             out  5   0=none, 5'd1=layer1, 5'd2=layer2; registered
//  bias_sel               out  5   always equal to weight_sel
//  layer1_grant           out  1   layer1 owns the port; registered
//  layer2_grant           out  1   layer2 owns the port; registered
//  layer1_weight_valid    out  1   weight data on SRAM bus belongs to layer1
//  layer2_weight_valid    out  1   weight data on SRAM bus belongs to layer2
//  layer1_bias_valid      out  1   bias data on SRAM bus belongs to layer1
//  layer2_bias_valid      out  1   bias data on SRAM bus belongs to layer2
//  busy                   out  1   state != IDLE
//  timeout_flag           out  1   1-cycle pulse on forced release; tied 0 without macro
// BEHAVIOUR
//  Reset: all outputs 0; state=IDLE; last_owner=L2 (layer1 wins first tie); tag pipes cleared.
//  FSM states: IDLE, OWN_L1, OWN_L2, GAP.
//   IDLE: one req -> that owner next cycle. Both req -> the layer != last_owner.
//     No req -> stay in IDLE.
//   OWN_Lx: grant/sel held until owner's release pulse. Next cycle: GAP; last_owner=x.
//     Dropping req without release does not end ownership.
//     Release from the non-owner is ignored.
//     Release in the same cycle the grant first appears is honoured.
//   GAP: exactly 1 cycle with sel=0, grants=0; then IDLE arbitration (no new grant in GAP).
//   Min ownership switch: release at cycle t -> GAP at t+1 -> IDLE at t+2 -> new grant at t+3.
//  sel/grant are registered from next-state: grant rises 1 cycle after req is seen in IDLE.
//  Tagging:
//   Per-path shift pipe of depth READ_LATENCY, entries {vld, id}.
//   Weight path stage0 = {read_weight_signal_data, owner}; bias path uses read_bias_signal_data.
//   layerN_*_valid = tail.vld && tail.id==N.
//   Reads issued in the last owned cycle still tag correctly across GAP.
//  Strobes seen with no owner (IDLE/GAP) shift in vld=0.
//  Reset mid-operation: ownership and in-flight tags discarded; no valid strobe after reset.
// CONFIGURATION
//  SCHED_TIMEOUT_EN defined:
//   hold counter clears on grant and increments each OWN cycle.
//   At MAX_HOLD-1 with no release: forced transition to GAP; last_owner updated.
//   timeout_flag=1 for that cycle.
//  SCHED_TIMEOUT_EN undefined: no counter; ownership ends only by release; timeout_flag=0.
// TESTING
//  Reset: rst=1 mid-grant -> all outputs 0 asynchronously; after release, layer1 wins first tie.
//  Single: layer2_req at t0 -> layer2_grant=1 and weight_sel=bias_sel=2 at t1.
//    layer2_release at t5 -> sel=0 at t6.
//  Contention: both req held; owner releases each 4 cycles -> grants alternate L1,L2,L1,L2.
//    sel=0 for exactly 1 GAP cycle between grants.
//  Tagging, READ_LATENCY=2:
//    layer1 issues read strobe on its last owned cycle -> layer1_weight_valid=1 two cycles later.
//    layer2_weight_valid stays 0.
//  Ignored release: layer2_release pulse while L1 owns -> no change to grant or sel.
//  Timeout (macro on, MAX_HOLD=8): L1 holds, never releases -> at 8th owned cycle, timeout_flag pulse.
//    Then GAP; L2 (req) granted next.

Source files
------------

// File: rtl/weight_bias_read_scheduler.sv
// ============================================================================
// Module  : weight_bias_read_scheduler
// Brief   : Arbitrates the shared weight/bias SRAM read port between the layer1
//           and layer2 engines and tags returning read data with its issuer.
//           Optional macro SCHED_TIMEOUT_EN adds a MAX_HOLD ownership limit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module weight_bias_read_scheduler #(
  parameter int READ_LATENCY = 1,
  parameter int MAX_HOLD     = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       layer1_req,
  input  logic       layer2_req,
  input  logic       layer1_release,
  input  logic       layer2_release,
  input  logic       read_weight_signal_data,
  input  logic       read_bias_signal_data,
  output logic [4:0] weight_sel,
  output logic [4:0] bias_sel,
  output logic       layer1_grant,
  output logic       layer2_grant,
  output logic       layer1_weight_valid,
  output logic       layer2_weight_valid,
  output logic       layer1_bias_valid,
  output logic       layer2_bias_valid,
  output logic       busy,
  output logic       timeout_flag
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_OWN_L1 = 2'd1;
  localparam logic [1:0] ST_OWN_L2 = 2'd2;
  localparam logic [1:0] ST_GAP    = 2'd3;

  // last_owner: 0 = layer1, 1 = layer2
  logic [1:0] state_q, state_d;
  logic       last_owner_q, last_owner_d;
  logic [4:0] sel_q, sel_d;
  logic       grant1_q, grant1_d;
  logic       grant2_q, grant2_d;
  logic       hold_expired;
  logic       timeout_now;
  logic       owned;

  assign owned = (state_q == ST_OWN_L1) || (state_q == ST_OWN_L2);

`ifdef SCHED_TIMEOUT_EN
  localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;

  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

  // Counts owned cycles; zero on the first owned cycle since IDLE precedes every grant.
  always_comb begin
    hold_cnt_d = '0;
    if (owned) hold_cnt_d = hold_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hold_cnt_q <= '0;
    else     hold_cnt_q <= hold_cnt_d;
  end

  assign hold_expired = owned && (hold_cnt_q == HOLD_W'(MAX_HOLD - 1));
`else
  assign hold_expired = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    timeout_now  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (layer1_req && layer2_req) state_d = last_owner_q ? ST_OWN_L1 : ST_OWN_L2;
        else if (layer1_req)          state_d = ST_OWN_L1;
        else if (layer2_req)          state_d = ST_OWN_L2;
      end
      ST_OWN_L1: begin
        if (layer1_release || hold_expired) begin
          state_d      = ST_GAP;
          last_owner_d = 1'b0;
          timeout_now  = !layer1_release;
        end
      end
      ST_OWN_L2: begin
        if (layer2_release || hold_expired) begin
          state_d      = ST_GAP;
          last_owner_d = 1'b1;
          timeout_now  = !layer2_release;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Select and grants are registered from next-state so they align with state_q.
  always_comb begin
    sel_d    = 5'd0;
    grant1_d = 1'b0;
    grant2_d = 1'b0;
    if (state_d == ST_OWN_L1) begin
      sel_d    = 5'd1;
      grant1_d = 1'b1;
    end else if (state_d == ST_OWN_L2) begin
      sel_d    = 5'd2;
      grant2_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_owner_q <= 1'b1;
      sel_q        <= 5'd0;
      grant1_q     <= 1'b0;
      grant2_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      sel_q        <= sel_d;
      grant1_q     <= grant1_d;
      grant2_q     <= grant2_d;
    end
  end

  // Tag pipes: {vld, id} per stage, id 0 = layer1, 1 = layer2.
  logic [READ_LATENCY-1:0] wv_q, wv_d, wid_q, wid_d;
  logic [READ_LATENCY-1:0] bv_q, bv_d, bid_q, bid_d;

  assign wv_d[0]  = read_weight_signal_data && owned;
  assign wid_d[0] = (state_q == ST_OWN_L2);
  assign bv_d[0]  = read_bias_signal_data && owned;
  assign bid_d[0] = (state_q == ST_OWN_L2);

  for (genvar g = 1; g < READ_LATENCY; g++) begin : g_shift
    assign wv_d[g]  = wv_q[g-1];
    assign wid_d[g] = wid_q[g-1];
    assign bv_d[g]  = bv_q[g-1];
    assign bid_d[g] = bid_q[g-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wv_q  <= '0;
      wid_q <= '0;
      bv_q  <= '0;
      bid_q <= '0;
    end else begin
      wv_q  <= wv_d;
      wid_q <= wid_d;
      bv_q  <= bv_d;
      bid_q <= bid_d;
    end
  end

  assign weight_sel          = sel_q;
  assign bias_sel            = sel_q;
  assign layer1_grant        = grant1_q;
  assign layer2_grant        = grant2_q;
  assign layer1_weight_valid = wv_q[READ_LATENCY-1] && !wid_q[READ_LATENCY-1];
  assign layer2_weight_valid = wv_q[READ_LATENCY-1] &&  wid_q[READ_LATENCY-1];
  assign layer1_bias_valid   = bv_q[READ_LATENCY-1] && !bid_q[READ_LATENCY-1];
  assign layer2_bias_valid   = bv_q[READ_LATENCY-1] &&  bid_q[READ_LATENCY-1];
  assign busy                = (state_q != ST_IDLE);
  assign timeout_flag        = timeout_now;

endmodule

`default_nettype wire
